lcd_frame_streamer: RTL and testbench
=====================================

LCD_FRAME_STREAMER -- requirements
Module: lcd_frame_streamer

Interface
REQ-001 SHALL have parameter FRAME_BYTES, default 504, bytes per frame (84x48 panel, 6 banks).
REQ-002 SHALL have parameter WAIT_CYCLES, default 1000, clk cycles of idle after start before the first command.
REQ-003 SHALL have parameter VOP_CMD, default 8'hB1, contrast command byte.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1  one-cycle request to begin a frame sequence; ignored while busy.
REQ-007 SHALL have port fb_addr  output  9  frame-buffer read address.
REQ-008 SHALL have port fb_data  input  8  frame-buffer read data, valid exactly 1 cycle after fb_addr.
REQ-009 SHALL have port data  output  8  byte to spi_sender.
REQ-010 SHALL have port dc_in  output  1  0 = command, 1 = display data, to spi_sender.
REQ-011 SHALL have port spi_start  output  1  transfer request to spi_sender.
REQ-012 SHALL have port spi_done  input  1  transfer-complete from spi_sender.
REQ-013 SHALL have port busy  output  1  high from accepted start until the sequence ends.
REQ-014 SHALL have port frame_done  output  1  one-cycle pulse after the last data byte's spi_done.

Function
REQ-015 SHALL implement states IDLE, WAIT, INIT, ADDR, FETCH, SEND, HOLD, GAP.
REQ-016 IDLE->WAIT on start; WAIT counts WAIT_CYCLES then ->INIT.
REQ-017 INIT SHALL send, dc_in=0, the sequence 0x21, VOP_CMD, 0x04, 0x14, 0x20, 0x0C; then ->ADDR.
REQ-018 ADDR SHALL send, dc_in=0, 0x40 then 0x80; then ->FETCH with byte index 0.
REQ-019 FETCH SHALL drive fb_addr=index, capture fb_data one cycle later into data, set dc_in=1, ->SEND.
REQ-020 SEND/HOLD handshake: spi_start SHALL rise with data/dc_in already stable, remain high until spi_done is sampled high, then fall next cycle.
REQ-021 data and dc_in SHALL not change while spi_start is high.
REQ-022 GAP SHALL hold spi_start low at least 1 cycle and until spi_done is low before the next byte.
REQ-023 After spi_done of byte index FRAME_BYTES-1, SHALL pulse frame_done; index SHALL not wrap past FRAME_BYTES-1.
REQ-024 start asserted in any state but IDLE SHALL be ignored, no restart.
REQ-025 spi_done high while spi_start low SHALL be ignored.
REQ-026 Byte index counter SHALL be 9 bits; fb_addr SHALL equal index, zero in IDLE.

Reset
REQ-027 On rst_n low, immediately: state IDLE, data=0, dc_in=0, spi_start=0, fb_addr=0, busy=0, frame_done=0, counters 0.
REQ-028 Reset mid-transfer SHALL abort; after release, the block SHALL stay in IDLE until a new start.

Configuration
REQ-029 Macro LCD_CONTINUOUS_REFRESH_EN defined: after the last data byte, SHALL go to ADDR and stream again (frame_done pulses each frame, busy stays high, INIT not repeated).
REQ-030 Macro undefined: after the last data byte, SHALL return to IDLE with busy low the cycle frame_done pulses.

Structure
REQ-031 Shared package lcd_pkg SHALL hold the state encoding, command byte constants (0x21, 0x04, 0x14, 0x20, 0x0C, 0x40, 0x80) and default FRAME_BYTES.
REQ-032 Sub-module lcd_init_rom (index -> command byte, combinational) SHALL hold the INIT table.

Verification
REQ-033 start with WAIT_CYCLES=10, behavioural spi_sender model (done 20 cycles after start): first spi_start 10+ cycles later, data=0x21, dc_in=0.
REQ-034 Full frame, FRAME_BYTES=8, fb_data=addr^0xA5: 6 init + 2 addr cmds, then data 0xA5..0xA2, dc_in=1, one frame_done, busy low after.
REQ-035 Hold spi_done low 500 cycles: spi_start, data, dc_in constant throughout.
REQ-036 start pulsed mid-frame: no restart, byte count unchanged, single frame_done.
REQ-037 rst_n low during HOLD of data byte 3: all outputs 0 asynchronously, IDLE after release, no activity without start.
REQ-038 LCD_CONTINUOUS_REFRESH_EN defined: after frame 1, bytes 0x40, 0x80 resent, second frame_done after another 8 data bytes, busy stays high.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD frame streamer: FSM encoding, transfer phases,
// PCD8544-style command bytes and the default frame size.
package lcd_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_WAIT  = 3'd1;
  localparam state_t ST_INIT  = 3'd2;
  localparam state_t ST_ADDR  = 3'd3;
  localparam state_t ST_FETCH = 3'd4;
  localparam state_t ST_SEND  = 3'd5;
  localparam state_t ST_HOLD  = 3'd6;
  localparam state_t ST_GAP   = 3'd7;

  typedef enum logic [1:0] {
    PH_INIT = 2'd0,
    PH_ADDR = 2'd1,
    PH_DATA = 2'd2
  } phase_e;

  localparam logic [7:0] CMD_EXT    = 8'h21;
  localparam logic [7:0] CMD_TEMP   = 8'h04;
  localparam logic [7:0] CMD_BIAS   = 8'h14;
  localparam logic [7:0] CMD_BASIC  = 8'h20;
  localparam logic [7:0] CMD_NORMAL = 8'h0C;
  localparam logic [7:0] CMD_SET_Y  = 8'h40;
  localparam logic [7:0] CMD_SET_X  = 8'h80;

  localparam int DEFAULT_FRAME_BYTES = 504;
  localparam int INIT_LEN            = 6;

  // Cursor home: row address first, then column address.
  function automatic logic [7:0] addr_cmd(input logic sel);
    return sel ? CMD_SET_X : CMD_SET_Y;
  endfunction

endpackage

// File: rtl/lcd_init_rom.sv
// Combinational lookup of the panel power-up command sequence.
module lcd_init_rom
  import lcd_pkg::*;
#(
  parameter logic [7:0] VOP_CMD = 8'hB1
) (
  input  logic [2:0] idx,
  output logic [7:0] cmd
);

  always_comb begin
    cmd = CMD_NORMAL;
    case (idx)
      3'd0:    cmd = CMD_EXT;
      3'd1:    cmd = VOP_CMD;
      3'd2:    cmd = CMD_TEMP;
      3'd3:    cmd = CMD_BIAS;
      3'd4:    cmd = CMD_BASIC;
      3'd5:    cmd = CMD_NORMAL;
      default: cmd = CMD_NORMAL;
    endcase
  end

endmodule

// File: rtl/lcd_frame_streamer.sv
// Streams panel init, cursor-home and frame-buffer bytes to an SPI sender.
// Define LCD_CONTINUOUS_REFRESH_EN to loop back to cursor-home after every frame.
module lcd_frame_streamer
  import lcd_pkg::*;
#(
  parameter int         FRAME_BYTES = DEFAULT_FRAME_BYTES,
  parameter int         WAIT_CYCLES = 1000,
  parameter logic [7:0] VOP_CMD     = 8'hB1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic [8:0] fb_addr,
  input  logic [7:0] fb_data,
  output logic [7:0] data,
  output logic       dc_in,
  output logic       spi_start,
  input  logic       spi_done,
  output logic       busy,
  output logic       frame_done
);

  localparam int WAIT_LAST = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;
  localparam int WAIT_W    = (WAIT_LAST > 0) ? $clog2(WAIT_LAST + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_END = WAIT_W'(WAIT_LAST);
  localparam logic [8:0] LAST_BYTE = 9'(FRAME_BYTES - 1);
  localparam logic [2:0] INIT_LAST = 3'(INIT_LEN - 1);

  state_t            state;
  state_t            gap_next;
  phase_e            phase;
  logic [2:0]        cmd_idx;
  logic [8:0]        byte_idx;
  logic [WAIT_W-1:0] wait_cnt;
  logic              fetch_ph;
  logic [7:0]        rom_cmd;

  assign fb_addr = byte_idx;

  lcd_init_rom #(
    .VOP_CMD (VOP_CMD)
  ) u_init_rom (
    .idx (cmd_idx),
    .cmd (rom_cmd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      gap_next   <= ST_IDLE;
      phase      <= PH_INIT;
      cmd_idx    <= '0;
      byte_idx   <= '0;
      wait_cnt   <= '0;
      fetch_ph   <= 1'b0;
      data       <= '0;
      dc_in      <= 1'b0;
      spi_start  <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_WAIT;
            busy     <= 1'b1;
            wait_cnt <= '0;
            phase    <= PH_INIT;
            cmd_idx  <= '0;
            byte_idx <= '0;
          end
        end
        ST_WAIT: begin
          if (wait_cnt == WAIT_END) begin
            state <= ST_INIT;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_INIT: begin
          data  <= rom_cmd;
          dc_in <= 1'b0;
          state <= ST_SEND;
        end
        ST_ADDR: begin
          data  <= addr_cmd(cmd_idx[0]);
          dc_in <= 1'b0;
          state <= ST_SEND;
        end
        // Synchronous frame-buffer RAM: read data lags the address by one cycle.
        ST_FETCH: begin
          if (!fetch_ph) begin
            fetch_ph <= 1'b1;
          end else begin
            fetch_ph <= 1'b0;
            data     <= fb_data;
            dc_in    <= 1'b1;
            state    <= ST_SEND;
          end
        end
        ST_SEND: begin
          spi_start <= 1'b1;
          state     <= ST_HOLD;
        end
        // Next-byte bookkeeping happens here so GAP only waits for spi_done to clear.
        ST_HOLD: begin
          if (spi_done) begin
            spi_start <= 1'b0;
            state     <= ST_GAP;
            case (phase)
              PH_INIT: begin
                if (cmd_idx == INIT_LAST) begin
                  phase    <= PH_ADDR;
                  cmd_idx  <= '0;
                  gap_next <= ST_ADDR;
                end else begin
                  cmd_idx  <= cmd_idx + 1'b1;
                  gap_next <= ST_INIT;
                end
              end
              PH_ADDR: begin
                if (cmd_idx[0]) begin
                  phase    <= PH_DATA;
                  cmd_idx  <= '0;
                  byte_idx <= '0;
                  gap_next <= ST_FETCH;
                end else begin
                  cmd_idx  <= cmd_idx + 1'b1;
                  gap_next <= ST_ADDR;
                end
              end
              PH_DATA: begin
                if (byte_idx == LAST_BYTE) begin
                  frame_done <= 1'b1;
                  byte_idx   <= '0;
                  cmd_idx    <= '0;
`ifdef LCD_CONTINUOUS_REFRESH_EN
                  phase      <= PH_ADDR;
                  gap_next   <= ST_ADDR;
`else
                  phase      <= PH_INIT;
                  gap_next   <= ST_IDLE;
                  state      <= ST_IDLE;
                  busy       <= 1'b0;
`endif
                end else begin
                  byte_idx <= byte_idx + 1'b1;
                  gap_next <= ST_FETCH;
                end
              end
              default: begin
                phase    <= PH_INIT;
                gap_next <= ST_IDLE;
              end
            endcase
          end
        end
        ST_GAP: begin
          if (!spi_done) begin
            state <= gap_next;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_frame_streamer.sv
// Directed bench for lcd_frame_streamer with a behavioural SPI sender and frame-buffer RAM.
module tb_lcd_frame_streamer;

  localparam int FB = 8;
  localparam int WC = 10;
`ifdef LCD_CONTINUOUS_REFRESH_EN
  localparam int  NFRAMES    = 2;
  localparam logic BUSY_AT_FD = 1'b1;
`else
  localparam int  NFRAMES    = 1;
  localparam logic BUSY_AT_FD = 1'b0;
`endif
  localparam int EXP_N = 6 + NFRAMES * (FB + 2);

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [8:0] fb_addr;
  logic [7:0] fb_data = 8'h00;
  logic [7:0] data;
  logic       dc_in;
  logic       spi_start;
  logic       spi_done;
  logic       busy;
  logic       frame_done;

  logic       model_done;
  logic       inject = 1'b0;
  logic       hold_low = 1'b0;
  int         scnt;

  int errors = 0;
  int checks = 0;

  logic [8:0] log_q[$];
  logic [8:0] cur;
  logic       sp_q = 1'b0;
  int stable_err = 0;
  int gap_err = 0;
  int busy_err = 0;
  int fd_cnt = 0;

  logic [7:0] cmds [8] = '{8'h21, 8'hB1, 8'h04, 8'h14, 8'h20, 8'h0C, 8'h40, 8'h80};

  always #5 clk = ~clk;

  lcd_frame_streamer #(
    .FRAME_BYTES (FB),
    .WAIT_CYCLES (WC),
    .VOP_CMD     (8'hB1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .fb_addr    (fb_addr),
    .fb_data    (fb_data),
    .data       (data),
    .dc_in      (dc_in),
    .spi_start  (spi_start),
    .spi_done   (spi_done),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always @(posedge clk) fb_data <= fb_addr[7:0] ^ 8'hA5;

  // SPI sender: done 20 cycles after start, held until start drops.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_done <= 1'b0;
      scnt       <= 0;
    end else if (spi_start) begin
      if (!model_done && !hold_low) begin
        if (scnt == 19) model_done <= 1'b1;
        else scnt <= scnt + 1;
      end
    end else begin
      model_done <= 1'b0;
      scnt       <= 0;
    end
  end
  assign spi_done = model_done | inject;

  always @(negedge clk) begin
    if (spi_start && !sp_q) begin
      log_q.push_back({dc_in, data});
      cur = {dc_in, data};
      if (spi_done) gap_err++;
    end else if (spi_start && ({dc_in, data} !== cur)) begin
      stable_err++;
    end
    if (frame_done) begin
      fd_cnt++;
      if (busy !== BUSY_AT_FD) busy_err++;
    end
    sp_q = spi_start;
  end

  function automatic logic [8:0] exp_at(input int i);
    int m;
    if (i < 6) return {1'b0, cmds[i]};
    m = (i - 6) % (FB + 2);
    if (m < 2) return {1'b0, cmds[6 + m]};
    return {1'b1, 8'(m - 2) ^ 8'hA5};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    inject = 1'b0;
    hold_low = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #2;
    checks++; if (data !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", data); end
    checks++; if (dc_in !== 1'b0) begin errors++; $display("FAIL reset_dc got=%b exp=0", dc_in); end
    checks++; if (spi_start !== 1'b0) begin errors++; $display("FAIL reset_spi_start got=%b exp=0", spi_start); end
    checks++; if (fb_addr !== 9'd0) begin errors++; $display("FAIL reset_fb_addr got=%0d exp=0", fb_addr); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got=%b exp=0", frame_done); end
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #2;
    checks++; if (log_q.size() !== 0 || busy !== 1'b0) begin
      errors++; $display("FAIL idle_no_activity transfers=%0d busy=%b exp=0/0", log_q.size(), busy);
    end
  endtask

  task automatic test_first_cmd();
    int cyc;
    bit seen;
    pulse_start();
    cyc = 1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL start_busy got=%b exp=1", busy); end
    inject = 1'b1;
    repeat (2) begin @(posedge clk); #2; cyc++; end
    inject = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(posedge clk); #2; cyc++;
      if (spi_start) begin seen = 1'b1; break; end
    end
    checks++; if (!seen) begin errors++; $display("FAIL first_spi_start timeout got=0 exp=1"); end
    checks++; if (cyc < WC) begin errors++; $display("FAIL first_latency got=%0d exp>=%0d", cyc, WC); end
    checks++; if (data !== 8'h21) begin errors++; $display("FAIL first_data got=%h exp=21", data); end
    checks++; if (dc_in !== 1'b0) begin errors++; $display("FAIL first_dc got=%b exp=0", dc_in); end
  endtask

  task automatic test_full_frame();
    int base_fd;
    bit seen;
    base_fd = fd_cnt;
    seen = 1'b0;
    for (int n = 0; n < 5000; n++) begin
      @(posedge clk); #2;
      if (fd_cnt >= base_fd + NFRAMES) begin seen = 1'b1; break; end
    end
    checks++; if (!seen) begin errors++; $display("FAIL frame_timeout frames=%0d exp=%0d", fd_cnt - base_fd, NFRAMES); end
    checks++; if (log_q.size() !== EXP_N) begin errors++; $display("FAIL frame_count got=%0d exp=%0d", log_q.size(), EXP_N); end
    for (int i = 0; i < EXP_N && i < log_q.size(); i++) begin
      checks++;
      if (log_q[i] !== exp_at(i)) begin
        errors++; $display("FAIL frame_byte[%0d] got dc=%b d=%h exp dc=%b d=%h", i, log_q[i][8], log_q[i][7:0], exp_at(i) >> 8, exp_at(i) & 9'hFF);
      end
    end
    repeat (60) @(posedge clk);
    #2;
    checks++; if (busy !== BUSY_AT_FD) begin errors++; $display("FAIL after_frame_busy got=%b exp=%b", busy, BUSY_AT_FD); end
`ifndef LCD_CONTINUOUS_REFRESH_EN
    checks++; if (fd_cnt - base_fd !== 1) begin errors++; $display("FAIL frame_done_count got=%0d exp=1", fd_cnt - base_fd); end
    checks++; if (fb_addr !== 9'd0) begin errors++; $display("FAIL idle_fb_addr got=%0d exp=0", fb_addr); end
    checks++; if (log_q.size() !== EXP_N) begin errors++; $display("FAIL after_frame_extra got=%0d exp=%0d", log_q.size(), EXP_N); end
`endif
    checks++; if (busy_err !== 0) begin errors++; $display("FAIL busy_at_frame_done violations=%0d exp=0", busy_err); end
    checks++; if (stable_err !== 0) begin errors++; $display("FAIL data_stable violations=%0d exp=0", stable_err); end
    checks++; if (gap_err !== 0) begin errors++; $display("FAIL gap_spi_done violations=%0d exp=0", gap_err); end
  endtask

  task automatic test_stall();
    int base;
    int viol;
    bit seen;
    do_reset();
    base = log_q.size();
    pulse_start();
    seen = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(posedge clk); #2;
      if (spi_start) begin seen = 1'b1; break; end
    end
    hold_low = 1'b1;
    checks++; if (!seen) begin errors++; $display("FAIL stall_start timeout got=0 exp=1"); end
    viol = 0;
    repeat (500) begin
      @(posedge clk); #2;
      if (spi_start !== 1'b1 || data !== 8'h21 || dc_in !== 1'b0) viol++;
    end
    checks++; if (viol !== 0) begin errors++; $display("FAIL stall_hold changed_cycles=%0d exp=0", viol); end
    checks++; if (log_q.size() !== base + 1) begin errors++; $display("FAIL stall_transfers got=%0d exp=1", log_q.size() - base); end
    hold_low = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #2;
      if (log_q.size() >= base + 2) begin seen = 1'b1; break; end
    end
    checks++; if (!seen || log_q[base + 1] !== {1'b0, 8'hB1}) begin
      errors++; $display("FAIL stall_resume got=%0d exp=1 (second byte B1)", seen);
    end
  endtask

  task automatic test_start_ignored();
    int base;
    int base_fd;
    int at_fd;
    bit seen;
    do_reset();
    base = log_q.size();
    base_fd = fd_cnt;
    pulse_start();
    @(posedge clk); #2;
    pulse_start();
    for (int n = 0; n < 2000; n++) begin
      @(posedge clk); #2;
      if (log_q.size() >= base + 10) break;
    end
    pulse_start();
    seen = 1'b0;
    at_fd = 0;
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #2;
      if (fd_cnt > base_fd) begin seen = 1'b1; at_fd = log_q.size() - base; break; end
      if (n % 50 == 0) start = 1'b1; else start = 1'b0;
    end
    start = 1'b0;
    checks++; if (!seen) begin errors++; $display("FAIL restart_frame_timeout got=0 exp=1"); end
    checks++; if (at_fd !== 16) begin errors++; $display("FAIL restart_byte_count got=%0d exp=16", at_fd); end
    checks++; if (log_q[base + 6] !== {1'b0, 8'h40} || log_q[base + 15] !== {1'b1, 8'hA2}) begin
      errors++; $display("FAIL restart_sequence got=%h/%h exp=040/1a2", log_q[base + 6], log_q[base + 15]);
    end
`ifndef LCD_CONTINUOUS_REFRESH_EN
    repeat (100) @(posedge clk);
    #2;
    checks++; if (fd_cnt - base_fd !== 1 || log_q.size() - base !== 16) begin
      errors++; $display("FAIL restart_single_frame frames=%0d bytes=%0d exp=1/16", fd_cnt - base_fd, log_q.size() - base);
    end
`endif
  endtask

  task automatic test_reset_mid();
    int base;
    bit seen;
    do_reset();
    base = log_q.size();
    pulse_start();
    seen = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #2;
      if (log_q.size() >= base + 12 && spi_start) begin seen = 1'b1; break; end
    end
    checks++; if (!seen || log_q[base + 11] !== {1'b1, 8'hA6}) begin
      errors++; $display("FAIL mid_reach_byte3 got=%0d exp=1", seen);
    end
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if ({data, dc_in, spi_start, busy, frame_done} !== 12'h000 || fb_addr !== 9'd0) begin
      errors++; $display("FAIL mid_async_reset data=%h dc=%b spi=%b busy=%b fd=%b addr=%0d exp all 0",
                         data, dc_in, spi_start, busy, frame_done, fb_addr);
    end
    @(posedge clk); #2;
    rst_n = 1'b1;
    base = log_q.size();
    repeat (200) @(posedge clk);
    #2;
    checks++; if (log_q.size() !== base || busy !== 1'b0 || spi_start !== 1'b0 || fb_addr !== 9'd0) begin
      errors++; $display("FAIL mid_stay_idle transfers=%0d busy=%b spi=%b addr=%0d exp 0", log_q.size() - base, busy, spi_start, fb_addr);
    end
  endtask

  initial begin
    test_reset();
    test_first_cmd();
    test_full_frame();
    test_stall();
    test_start_ignored();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
